wb_dmem_slave: RTL and testbench
================================

// Module: wb_dmem_slave
// PURPOSE
//  Wishbone classic single-port data-memory responder: the slave end serving the MEM-stage LSU master.
//  Accepts 32-bit read/write transfers with byte selects and stores data in an internal word array.
//  Answers with a registered ack (or err), optionally after fixed wait states. Sits on the data bus between the core and RAM.
// PARAMETERS
//  DEPTH_WORDS   1024  number of 32-bit words; power of two, >=2
//  WAIT_STATES   0     extra cycles between request capture and ack (0..15)
// PORTS
//  clk_i       in   1   clock; single clock domain
//  rst_i       in   1   reset; synchronous, active-high
//  wbs_cyc_i   in   1   bus cycle valid
//  wbs_stb_i   in   1   strobe; transfer request
//  wbs_we_i    in   1   1 = write, 0 = read
//  wbs_addr_i  in   32  byte address; [1:0] ignored
//  wbs_dat_i   in   32  write data
//  wbs_sel_i   in   4   byte lane enables; sel[n] -> dat[8n+7:8n]
//  wbs_dat_o   out  32  read data, valid while wbs_ack_o=1
//  wbs_ack_o   out  1   transfer done, one-cycle pulse
//  wbs_err_o   out  1   transfer failed, one-cycle pulse (WBS_RANGE_ERR_EN only)
// BEHAVIOUR
//  Reset: state IDLE, wait counter 0, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=32'h0. Memory contents are not cleared.
//  States: IDLE, WAIT, RESP.
//  - IDLE: when cyc&stb=1, capture addr, dat, sel and we. Go to WAIT if WAIT_STATES>0, else RESP.
//  - WAIT: count down WAIT_STATES cycles, then go to RESP. If cyc_i drops, go to IDLE: no write, no ack.
//  - RESP: drive ack (or err) high for exactly one cycle, then return to IDLE.
//  Commit rules:
//  - The write is committed on the clock edge that leaves RESP.
//  - Read data is loaded into wbs_dat_o on entry to RESP.
//  - wbs_dat_o holds its last value otherwise.
//  Latency:
//  - Request sampled at edge N -> ack high during cycle N+1+WAIT_STATES.
//  - Back-to-back requests: the earliest next capture is the cycle after ack. Maximum rate is 1 transfer per 2 cycles.
//  Word index = wbs_addr_i[$clog2(DEPTH_WORDS)+1:2]. Reads return the full word; sel is ignored on reads.
//  A write with sel=4'b0000 acks normally and changes no bytes.
//  ack and err are never high in the same cycle.
//  cyc=1 with stb=0 in IDLE: no action.
//  Reset asserted mid-transfer: return to IDLE on the next edge, drop any pending write, no ack/err.
// CONFIGURATION
//  WBS_RANGE_ERR_EN defined:
//  - A byte address >= DEPTH_WORDS*4 completes with wbs_err_o instead of ack.
//  - No write occurs and wbs_dat_o is unchanged. Latency is the same as ack.
//  WBS_RANGE_ERR_EN undefined:
//  - Upper address bits are ignored, so addresses wrap modulo the memory size.
//  - wbs_err_o is tied to 0.
// STRUCTURE
//  Shared package wb_pkg:
//  - WB_ADDR_W=32, WB_DATA_W=32, WB_SEL_W=4.
//  - State encoding constants S_IDLE, S_WAIT, S_RESP.
//  Sub-module wb_dmem_array:
//  - Byte-enabled synchronous word RAM (we, sel, index, wdata, rdata).
//  - Keeps storage separate from the handshake FSM so it can be swapped for an SRAM macro.
// TESTING
//  1. WAIT_STATES=0: write 32'hDEADBEEF, sel=4'hF to 0x10, then read 0x10 -> ack 1 cycle after each request; read returns 32'hDEADBEEF.
//  2. Byte lanes: word 0x20 = 32'h11223344; write 32'hAABBCCDD with sel=4'b0101 -> read gives 32'h11BB33DD.
//  3. WAIT_STATES=3: read request at edge N -> ack high exactly in cycle N+4, only for 1 cycle; no ack before.
//  4. Abort: WAIT_STATES=3, write 32'h5 to 0x40, drop cyc_i after 1 wait cycle -> no ack; later read of 0x40 returns the old value.
//  5. Range (DEPTH_WORDS=1024), access to 0x1000:
//     - WBS_RANGE_ERR_EN defined -> err pulse, ack=0, memory unchanged.
//     - WBS_RANGE_ERR_EN undefined -> ack; data aliases word 0.
//  6. Reset: rst_i=1 during WAIT of a write to 0x8 -> ack/err stay 0, dat_o=0, FSM idle; word 0x8 is unchanged.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone bus widths and responder FSM state encoding
package wb_pkg;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/wb_dmem_slave_if.sv
// wb_dmem_slave_if: Wishbone classic data-bus signals with master/slave views
interface wb_dmem_slave_if;
  import wb_pkg::*;
  logic                 wbs_cyc_i;
  logic                 wbs_stb_i;
  logic                 wbs_we_i;
  logic [WB_ADDR_W-1:0] wbs_addr_i;
  logic [WB_DATA_W-1:0] wbs_dat_i;
  logic [WB_SEL_W-1:0]  wbs_sel_i;
  logic [WB_DATA_W-1:0] wbs_dat_o;
  logic                 wbs_ack_o;
  logic                 wbs_err_o;
  modport slave (input wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_addr_i, wbs_dat_i, wbs_sel_i,
                 output wbs_dat_o, wbs_ack_o, wbs_err_o);
  modport master (output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_addr_i, wbs_dat_i, wbs_sel_i,
                  input wbs_dat_o, wbs_ack_o, wbs_err_o);
endinterface

// File: rtl/wb_dmem_array.sv
// wb_dmem_array: byte-enabled synchronous word RAM with a held, resettable read register
module wb_dmem_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           i_re,
  input  logic                           i_we,
  input  logic [3:0]                     i_sel,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);
  logic [31:0] r_mem [DEPTH_WORDS];
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++)
      if (i_we && i_sel[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
  end
  // read register only moves on a real read so the bus data holds between transfers
  always_ff @(posedge clk_i) begin
    if (rst_i) o_rdata <= 32'h0;
    else if (i_re) o_rdata <= r_mem[i_idx];
  end
endmodule

// File: rtl/wb_dmem_slave.sv
// wb_dmem_slave: Wishbone classic data-memory responder; WBS_RANGE_ERR_EN enables out-of-range err
module wb_dmem_slave
  import wb_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic             clk_i,
  input logic             rst_i,
  wb_dmem_slave_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LD = WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
  state_t      r_state, w_next;
  logic [3:0]  r_cnt, r_sel;
  logic [31:0] r_addr, r_dat, w_addr;
  logic        r_we, w_req, w_we, w_oor, w_re, w_wr, w_unused;
  assign w_req  = bus.wbs_cyc_i & bus.wbs_stb_i;
  // in IDLE the live request feeds the RAM so zero-wait reads land on entry to RESP
  assign w_addr = r_state == S_IDLE ? bus.wbs_addr_i : r_addr;
  assign w_we   = r_state == S_IDLE ? bus.wbs_we_i : r_we;
`ifdef WBS_RANGE_ERR_EN
  assign w_oor  = w_addr >= 32'(DEPTH_WORDS * 4);
`else
  assign w_oor  = 1'b0;
`endif
  assign w_unused = ^{w_addr[1:0], w_addr[31:AW+2]};
  always_comb begin
    w_next = r_state == S_IDLE ? (w_req ? (WAIT_STATES > 0 ? S_WAIT : S_RESP) : S_IDLE) :
             r_state == S_WAIT ? (!bus.wbs_cyc_i ? S_IDLE : r_cnt == 4'd0 ? S_RESP : S_WAIT) :
             S_IDLE;
    w_re   = w_next == S_RESP && r_state != S_RESP && !w_we && !w_oor && !rst_i;
    w_wr   = r_state == S_RESP && r_we && !w_oor && !rst_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_req) begin
        r_addr <= bus.wbs_addr_i;
        r_dat  <= bus.wbs_dat_i;
        r_sel  <= bus.wbs_sel_i;
        r_we   <= bus.wbs_we_i;
        r_cnt  <= CNT_LD;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt  <= r_cnt - 4'd1;
      end
    end
  end
  assign bus.wbs_ack_o = r_state == S_RESP && !w_oor;
  assign bus.wbs_err_o = r_state == S_RESP && w_oor;
  wb_dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_re    (w_re),
    .i_we    (w_wr),
    .i_sel   (r_sel),
    .i_idx   (w_addr[AW+1:2]),
    .i_wdata (r_dat),
    .o_rdata (bus.wbs_dat_o)
  );
endmodule

// File: tb/tb_wb_dmem_slave.sv
// tb_wb_dmem_slave: directed checks of wb_dmem_slave with zero and three wait states
module tb_wb_dmem_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  wb_dmem_slave_if b0 ();
  wb_dmem_slave_if b3 ();
  wb_dmem_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (.clk_i(clk), .rst_i(rst), .bus(b0));
  wb_dmem_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (.clk_i(clk), .rst_i(rst), .bus(b3));
  int          dut = 0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  logic        ack, err;
  logic [31:0] rdat;
  assign b0.wbs_cyc_i  = cyc & (dut == 0);
  assign b0.wbs_stb_i  = stb & (dut == 0);
  assign b3.wbs_cyc_i  = cyc & (dut == 3);
  assign b3.wbs_stb_i  = stb & (dut == 3);
  assign b0.wbs_we_i   = we;
  assign b3.wbs_we_i   = we;
  assign b0.wbs_addr_i = addr;
  assign b3.wbs_addr_i = addr;
  assign b0.wbs_dat_i  = wdat;
  assign b3.wbs_dat_i  = wdat;
  assign b0.wbs_sel_i  = sel;
  assign b3.wbs_sel_i  = sel;
  assign ack  = dut == 0 ? b0.wbs_ack_o : b3.wbs_ack_o;
  assign err  = dut == 0 ? b0.wbs_err_o : b3.wbs_err_o;
  assign rdat = dut == 0 ? b0.wbs_dat_o : b3.wbs_dat_o;
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output int lat, output logic k, output logic e);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s;
    lat = 0; rd = 'x; k = 1'b0; e = 1'b0;
    @(posedge clk);
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (ack | err) begin lat = i; rd = rdat; k = ack; e = err; end
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("pulse_width", {30'b0, ack, err}, 32'h0);
  endtask
  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int el);
    logic [31:0] rd; int lat; logic k, e;
    xfer(1'b1, a, d, s, rd, lat, k, e);
    chk({tag, "_lat"}, 32'(lat), 32'(el));
    chk({tag, "_ack"}, {30'b0, k, e}, 32'h2);
  endtask
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp, input int el);
    logic [31:0] rd; int lat; logic k, e;
    xfer(1'b0, a, 32'h0, 4'h0, rd, lat, k, e);
    chk({tag, "_lat"}, 32'(lat), 32'(el));
    chk({tag, "_ack"}, {30'b0, k, e}, 32'h2);
    chk({tag, "_data"}, rd, exp);
  endtask
  initial begin
    logic [31:0] rd; int lat, highs; logic k, e;
    repeat (3) @(negedge clk);
    chk("rst_ack0", {30'b0, b0.wbs_ack_o, b0.wbs_err_o}, 32'h0);
    chk("rst_dat0", b0.wbs_dat_o, 32'h0);
    chk("rst_ack3", {30'b0, b3.wbs_ack_o, b3.wbs_err_o}, 32'h0);
    chk("rst_dat3", b3.wbs_dat_o, 32'h0);
    rst = 1'b0;
    dut = 0;
    wr("w0_beef", 32'h10, 32'hDEADBEEF, 4'hF, 1);
    rd_chk("r0_beef", 32'h10, 32'hDEADBEEF, 1);
    wr("w0_base", 32'h20, 32'h11223344, 4'hF, 1);
    wr("w0_lanes", 32'h20, 32'hAABBCCDD, 4'b0101, 1);
    rd_chk("r0_lanes", 32'h20, 32'h11BB33DD, 1);
    wr("w0_sel0", 32'h20, 32'hFFFFFFFF, 4'b0000, 1);
    rd_chk("r0_sel0", 32'h20, 32'h11BB33DD, 1);
    wr("w0_word0", 32'h0, 32'hCAFEF00D, 4'hF, 1);
    rd_chk("r0_word0", 32'h0, 32'hCAFEF00D, 1);
    xfer(1'b1, 32'h1000, 32'h01020304, 4'hF, rd, lat, k, e);
    chk("range_w_lat", 32'(lat), 32'd1);
`ifdef WBS_RANGE_ERR_EN
    chk("range_w_err", {30'b0, k, e}, 32'h1);
    rd_chk("range_w_nochg", 32'h0, 32'hCAFEF00D, 1);
    xfer(1'b0, 32'h1000, 32'h0, 4'h0, rd, lat, k, e);
    chk("range_r_err", {30'b0, k, e}, 32'h1);
    chk("range_r_dat", rd, 32'hCAFEF00D);
`else
    chk("range_w_ack", {30'b0, k, e}, 32'h2);
    rd_chk("range_alias", 32'h0, 32'h01020304, 1);
`endif
    dut = 3;
    wr("w3", 32'h30, 32'h0000A5A5, 4'hF, 4);
    rd_chk("r3", 32'h30, 32'h0000A5A5, 4);
    wr("w3_old", 32'h40, 32'h00000077, 4'hF, 4);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h40; wdat = 32'h5; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("abort_wait", {30'b0, ack, err}, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    highs = 0;
    repeat (6) begin @(negedge clk); highs += int'(ack | err); end
    chk("abort_noack", 32'(highs), 32'h0);
    rd_chk("abort_keep", 32'h40, 32'h00000077, 4);
    wr("w3_rst", 32'h8, 32'h12345678, 4'hF, 4);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h8; wdat = 32'h00000BAD; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack", {30'b0, ack, err}, 32'h0);
    chk("rst_mid_dat", rdat, 32'h0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    highs = 0;
    repeat (6) begin @(negedge clk); highs += int'(ack | err); end
    chk("rst_mid_noack", 32'(highs), 32'h0);
    rd_chk("rst_mid_keep", 32'h8, 32'h12345678, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
